teclado_ps2_ascii: RTL and testbench
====================================

Name: teclado_ps2_ascii

Overview:
- Receives a PS/2 keyboard (scan-code set 2) serial stream and produces the 8-bit ASCII character bus that feeds the game-mode FSMs, including free mode, on their `entrada` input.
- Handles frame reception, parity checking, break/extended prefixes and scan-code-to-ASCII mapping.
- Presents each new key press as a held ASCII byte plus a one-cycle valid strobe.

Parameters:
- TIMEOUT_CYCLES, 50000, system-clock cycles with no PS/2 falling edge inside a frame before the frame is abandoned (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages synchronising ps2_clk and ps2_data (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous.
- ps2_data  input  1  raw PS/2 data from the connector, asynchronous.
- entrada  output  8  ASCII code of the last accepted key press; held until the next one.
- valido  output  1  one-cycle pulse when entrada takes a new value.
- error_trama  output  1  one-cycle pulse on parity error, bad start/stop bit, or timeout.

Behaviour:
- Reset (reset=0, asynchronous): entrada=8'h00, valido=0, error_trama=0, frame FSM=ESPERA, decode FSM=NORMAL, bit counter=0, timeout counter=0, synchronisers=1.
- Synchronisation: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is detected when the previous synced clk is 1 and the current is 0. Data is sampled on the detect cycle.
- Frame FSM states:
  - ESPERA: on a falling edge with data=0 (start bit) -> DATOS, counter=0. If data=1, stay in ESPERA and pulse error_trama.
  - DATOS: shift 8 bits in, LSB first; after the 8th bit -> PARIDAD.
  - PARIDAD: capture the parity bit -> PARADA.
  - PARADA: check stop=1 and odd parity (data bits plus parity bit have an odd number of ones). If OK, raise the internal byte-ready for 1 cycle; otherwise pulse error_trama and drop the byte. Go to ESPERA in both cases.
- Timeout: counter clears on every falling edge and on entering ESPERA. In any state other than ESPERA, reaching TIMEOUT_CYCLES-1 -> ESPERA, pulse error_trama, discard partial byte.
- Decode FSM, advanced by a valid byte only:
  - NORMAL:
    - F0 -> RUPTURA.
    - E0 -> EXTENDIDO.
    - Mapped code -> output it.
    - Unmapped code -> ignored.
  - RUPTURA: any byte -> NORMAL, no output (key release).
  - EXTENDIDO: F0 -> EXT_RUPTURA; any other byte -> NORMAL, no output (extended keys unmapped).
  - EXT_RUPTURA: any byte -> NORMAL, no output.
- Mapping (set 2 -> ASCII):
  - Letters, uppercase: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - Digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
  - Others: space 29->20, enter 5A->0D, backspace 66->08.
- Latency: entrada and valido update on the rising edge after the cycle in which the stop bit is sampled. valido is high for exactly 1 cycle.
- Typematic repeat: a repeated make code without an intervening F0 produces a new valido each time. The same ASCII value is re-emitted.
- An error does not change the decode FSM state and does not touch entrada.
- Reset mid-frame or mid-prefix returns to the reset state immediately, and the partial frame is lost.

Test Plan:
- Reset then idle lines high -> entrada=00, valido=0, error_trama=0 for 1000 cycles.
- Frame 1C (parity 0, stop 1) at 10 kHz PS/2 clock -> entrada=41, one valido pulse; then F0,1C -> no valido, entrada stays 41.
- Sequence 1C,32,21,23 with F0 releases between them -> entrada=41,42,43,44, four valido pulses.
- Frame 1C with parity bit flipped to 1 -> error_trama pulse, no valido, entrada unchanged. Next good 32 -> entrada=42.
- Stop after 4 data bits, wait TIMEOUT_CYCLES -> error_trama pulse, FSM in ESPERA. Next full frame 29 -> entrada=20.
- E0,75 (up arrow) then E0,F0,75 -> no valido. Then 5A -> entrada=0D. Assert reset mid-frame -> entrada=00 immediately.

Source files
------------

// File: rtl/teclado_ps2_ascii_if.sv
// -----------------------------------------------------------------------------
// teclado_ps2_ascii_if
// Groups the PS/2 connector lines and the ASCII character bus of the keyboard
// receiver.
//   ps2_clk, ps2_data : raw PS/2 lines from the connector (asynchronous)
//   entrada           : ASCII code of the last accepted key press (held)
//   valido            : one-cycle strobe when entrada takes a new value
//   error_trama       : one-cycle strobe on parity/start/stop error or timeout
// Modports: master = keyboard side / consumer (drives the PS/2 lines),
//           slave  = receiver (teclado_ps2_ascii).
// -----------------------------------------------------------------------------
interface teclado_ps2_ascii_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] entrada;
  logic       valido;
  logic       error_trama;

  modport master (output ps2_clk, ps2_data,
                  input  entrada, valido, error_trama);
  modport slave  (input  ps2_clk, ps2_data,
                  output entrada, valido, error_trama);
endinterface

// File: rtl/teclado_ps2_ascii.sv
// -----------------------------------------------------------------------------
// teclado_ps2_ascii
// PS/2 keyboard receiver (scan-code set 2) producing ASCII characters for the
// game-mode FSMs. Synchronises the PS/2 lines, receives 11-bit frames, checks
// start/parity/stop, tracks break (F0) and extended (E0) prefixes and maps
// make codes of letters, digits, space, enter and backspace to ASCII.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : teclado_ps2_ascii_if.slave (PS/2 lines in, ASCII bus out)
// -----------------------------------------------------------------------------
module teclado_ps2_ascii #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  teclado_ps2_ascii_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ESPERA, DATOS, PARIDAD, PARADA} frame_t;
  typedef enum logic [1:0] {NORMAL, RUPTURA, EXTENDIDO, EXT_RUPTURA} dec_t;

  // Returns {mapped, ascii}; mapped=0 for codes with no ASCII equivalent.
  function automatic logic [8:0] map_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 8'h41}; 8'h32: return {1'b1, 8'h42};
      8'h21: return {1'b1, 8'h43}; 8'h23: return {1'b1, 8'h44};
      8'h24: return {1'b1, 8'h45}; 8'h2B: return {1'b1, 8'h46};
      8'h34: return {1'b1, 8'h47}; 8'h33: return {1'b1, 8'h48};
      8'h43: return {1'b1, 8'h49}; 8'h3B: return {1'b1, 8'h4A};
      8'h42: return {1'b1, 8'h4B}; 8'h4B: return {1'b1, 8'h4C};
      8'h3A: return {1'b1, 8'h4D}; 8'h31: return {1'b1, 8'h4E};
      8'h44: return {1'b1, 8'h4F}; 8'h4D: return {1'b1, 8'h50};
      8'h15: return {1'b1, 8'h51}; 8'h2D: return {1'b1, 8'h52};
      8'h1B: return {1'b1, 8'h53}; 8'h2C: return {1'b1, 8'h54};
      8'h3C: return {1'b1, 8'h55}; 8'h2A: return {1'b1, 8'h56};
      8'h1D: return {1'b1, 8'h57}; 8'h22: return {1'b1, 8'h58};
      8'h35: return {1'b1, 8'h59}; 8'h1A: return {1'b1, 8'h5A};
      8'h45: return {1'b1, 8'h30}; 8'h16: return {1'b1, 8'h31};
      8'h1E: return {1'b1, 8'h32}; 8'h26: return {1'b1, 8'h33};
      8'h25: return {1'b1, 8'h34}; 8'h2E: return {1'b1, 8'h35};
      8'h36: return {1'b1, 8'h36}; 8'h3D: return {1'b1, 8'h37};
      8'h3E: return {1'b1, 8'h38}; 8'h46: return {1'b1, 8'h39};
      8'h29: return {1'b1, 8'h20}; 8'h5A: return {1'b1, 8'h0D};
      8'h66: return {1'b1, 8'h08};
      default: return 9'h000;
    endcase
  endfunction

  // ---------------- synchronisers and falling-edge detect ----------------
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic                   r_clk_prev;
  logic                   w_fall, w_data;

  // NOTE: every clocked block uses non-blocking (<=) assignments so all flops
  // sample the pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_data = r_data_sync[SYNC_STAGES-1];

  // ---------------- frame FSM ----------------
  frame_t        r_frame, w_frame_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_parity;
  logic [TW-1:0] r_tmo;
  logic          w_byte_ok, w_frame_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_frame <= ESPERA;
    else        r_frame <= w_frame_next;
  end

  // NOTE: all outputs of a combinational block get a default first so no
  // path leaves them unassigned, which would infer a latch.
  always_comb begin
    w_frame_next = r_frame;
    w_byte_ok    = 1'b0;
    w_frame_err  = 1'b0;
    if (r_frame != ESPERA && !w_fall && r_tmo == TMO_LAST) begin
      w_frame_next = ESPERA;
      w_frame_err  = 1'b1;
    end else if (w_fall) begin
      case (r_frame)
        ESPERA:  if (!w_data) w_frame_next = DATOS;
                 else         w_frame_err  = 1'b1;
        DATOS:   if (r_bit_cnt == 3'd7) w_frame_next = PARIDAD;
        PARIDAD: w_frame_next = PARADA;
        PARADA: begin
          w_frame_next = ESPERA;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (w_data && (^{r_shift, r_parity})) w_byte_ok   = 1'b1;
          else                                  w_frame_err = 1'b1;
        end
        default: w_frame_next = ESPERA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_tmo     <= '0;
    end else begin
      if (w_fall || w_frame_next == ESPERA) r_tmo <= '0;
      else                                  r_tmo <= r_tmo + 1'b1;
      if (w_fall) begin
        case (r_frame)
          ESPERA:  r_bit_cnt <= '0;
          DATOS: begin
            r_shift   <= {w_data, r_shift[7:1]};  // LSB arrives first
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARIDAD: r_parity <= w_data;
          default: ;
        endcase
      end
    end
  end

  // ---------------- decode FSM ----------------
  dec_t       r_dec, w_dec_next;
  logic       w_emit;
  logic [8:0] w_map;

  assign w_map = map_ascii(r_shift);

  always_comb begin
    w_dec_next = r_dec;
    w_emit     = 1'b0;
    if (w_byte_ok) begin
      case (r_dec)
        NORMAL:
          if      (r_shift == 8'hF0) w_dec_next = RUPTURA;
          else if (r_shift == 8'hE0) w_dec_next = EXTENDIDO;
          else                       w_emit     = w_map[8];
        EXTENDIDO: w_dec_next = (r_shift == 8'hF0) ? EXT_RUPTURA : NORMAL;
        default:   w_dec_next = NORMAL;  // RUPTURA / EXT_RUPTURA swallow one byte
      endcase
    end
  end

  logic [7:0] r_entrada;
  logic       r_valido, r_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dec     <= NORMAL;
      r_entrada <= 8'h00;
      r_valido  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_dec    <= w_dec_next;
      r_valido <= w_emit;
      r_error  <= w_frame_err;
      if (w_emit) r_entrada <= w_map[7:0];
    end
  end

  assign bus.entrada     = r_entrada;
  assign bus.valido      = r_valido;
  assign bus.error_trama = r_error;

endmodule

// File: tb/tb_teclado_ps2_ascii.sv
// -----------------------------------------------------------------------------
// tb_teclado_ps2_ascii
// Drives PS/2 frames into teclado_ps2_ascii and checks the ASCII bus against a
// scoreboard of expected characters, plus counts of strobes and errors.
// -----------------------------------------------------------------------------
module tb_teclado_ps2_ascii;
  localparam int TMO  = 400;  // shortened timeout for simulation
  localparam int HALF = 40;   // PS/2 half-period in system clocks

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  teclado_ps2_ascii_if bus ();

  teclado_ps2_ascii #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int n_valid = 0, n_errp = 0, exp_valid = 0, exp_err = 0;
  logic [7:0] sb_q[$];
  logic prev_valido = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.valido) begin
        n_valid++;
        check("valido_one_cycle", {31'd0, prev_valido}, 32'd0);
        check("sb_pending", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) check("entrada", {24'd0, bus.entrada}, {24'd0, sb_q.pop_front()});
      end
      if (bus.error_trama) n_errp++;
      prev_valido = bus.valido;
    end else begin
      prev_valido = 1'b0;
    end
  end

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF / 2) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clk);
  endtask

  // Sends the first nbits of a frame; flip corrupts the parity bit.
  task automatic send_frame(input logic [7:0] code, input bit flip, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic key(input logic [7:0] code);
    send_frame(code, 1'b0, 11);
  endtask

  task automatic key_exp(input logic [7:0] code, input logic [7:0] ascii);
    sb_q.push_back(ascii);
    exp_valid++;
    send_frame(code, 1'b0, 11);
  endtask

  task automatic counts(input string tag);
    check({tag, "_valid_cnt"}, n_valid, exp_valid);
    check({tag, "_err_cnt"}, n_errp, exp_err);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    #1;
    check("rst_entrada", {24'd0, bus.entrada}, 32'h00);
    check("rst_valido", {31'd0, bus.valido}, 32'd0);
    repeat (3) @(posedge clk);
    reset = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("idle_entrada", {24'd0, bus.entrada}, 32'h00);
    check("idle_error", {31'd0, bus.error_trama}, 32'd0);
    counts("idle");

    // First key and its release
    key_exp(8'h1C, 8'h41);
    key(8'hF0); key(8'h1C);
    check("release_hold", {24'd0, bus.entrada}, 32'h41);
    counts("first");

    // A..D with releases
    key_exp(8'h1C, 8'h41); key(8'hF0); key(8'h1C);
    key_exp(8'h32, 8'h42); key(8'hF0); key(8'h32);
    key_exp(8'h21, 8'h43); key(8'hF0); key(8'h21);
    key_exp(8'h23, 8'h44); key(8'hF0); key(8'h23);
    counts("seq");

    // Parity error leaves entrada alone
    exp_err++;
    send_frame(8'h1C, 1'b1, 11);
    check("par_hold", {24'd0, bus.entrada}, 32'h44);
    counts("parity");
    key_exp(8'h32, 8'h42);

    // Timeout after 4 data bits
    exp_err++;
    send_frame(8'h55, 1'b0, 5);
    repeat (TMO + 50) @(posedge clk);
    counts("timeout");
    key_exp(8'h29, 8'h20);

    // Falling edge with data high while idle is a bad start bit
    exp_err++;
    ps2_bit(1'b1);
    repeat (HALF) @(posedge clk);
    counts("badstart");

    // Extended keys are swallowed; enter, typematic repeat, digit, backspace
    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h75);
    counts("extended");
    key_exp(8'h5A, 8'h0D);
    key_exp(8'h5A, 8'h0D);
    key_exp(8'h45, 8'h30);
    key_exp(8'h66, 8'h08);
    key(8'h76);  // unmapped
    counts("map");

    // Error during a release prefix keeps the decoder in release state
    key(8'hF0);
    exp_err++;
    send_frame(8'h1C, 1'b1, 11);
    key(8'h1C);  // consumed as release
    check("err_keeps_state", {24'd0, bus.entrada}, 32'h08);
    key_exp(8'h1C, 8'h41);
    counts("errstate");

    // Reset mid-frame
    send_frame(8'h32, 1'b0, 4);
    reset = 1'b0;
    #1;
    check("midrst_entrada", {24'd0, bus.entrada}, 32'h00);
    check("midrst_valido", {31'd0, bus.valido}, 32'd0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    key_exp(8'h1C, 8'h41);
    counts("after_reset");
    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
